// File: rtl/cordic_vector_seq.sv
// Iterative vectoring-mode CORDIC: (x,y) -> magnitude and atan2(y,x), one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to add a one-cycle GAIN state that removes the CORDIC gain from mag_out.
module cordic_vector_seq #(
  parameter int FRAC_BITS  = 20,
  parameter int ITERATIONS = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [FRAC_BITS+1:0] x_in,
  input  logic signed [FRAC_BITS+1:0] y_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [FRAC_BITS+3:0] mag_out,
  output logic signed [FRAC_BITS+2:0] angle_out
);

  localparam int IW = FRAC_BITS + 2;
  localparam int XW = FRAC_BITS + 4;
  localparam int ZW = FRAC_BITS + 3;
  localparam logic [4:0] LAST_IDX = 5'(ITERATIONS - 1);

  // Constants are held with 30 fraction bits and rounded to nearest at FRAC_BITS.
  localparam int LUT_SH = (FRAC_BITS <= 30) ? 30 - FRAC_BITS : 0;
  localparam int LUT_SL = (FRAC_BITS > 30) ? FRAC_BITS - 30 : 0;
  localparam logic [63:0] Q30_HALF = (64'd1 << LUT_SH) >> 1;

  function automatic logic [63:0] scale_q30(input logic [63:0] raw);
    return ((raw + Q30_HALF) >> LUT_SH) << LUT_SL;
  endfunction

  function automatic logic signed [ZW-1:0] atan_lut(input logic [4:0] idx);
    logic [63:0] raw;
    case (idx)
      5'd0:  raw = 64'd843314857;
      5'd1:  raw = 64'd497837829;
      5'd2:  raw = 64'd263043836;
      5'd3:  raw = 64'd133525159;
      5'd4:  raw = 64'd67021687;
      5'd5:  raw = 64'd33543516;
      5'd6:  raw = 64'd16775851;
      5'd7:  raw = 64'd8388437;
      5'd8:  raw = 64'd4194283;
      5'd9:  raw = 64'd2097149;
      5'd10: raw = 64'd1048576;
      5'd11: raw = 64'd524288;
      5'd12: raw = 64'd262144;
      5'd13: raw = 64'd131072;
      5'd14: raw = 64'd65536;
      5'd15: raw = 64'd32768;
      5'd16: raw = 64'd16384;
      5'd17: raw = 64'd8192;
      5'd18: raw = 64'd4096;
      5'd19: raw = 64'd2048;
      5'd20: raw = 64'd1024;
      5'd21: raw = 64'd512;
      5'd22: raw = 64'd256;
      5'd23: raw = 64'd128;
      default: raw = 64'd0;
    endcase
    return ZW'(scale_q30(raw));
  endfunction

  localparam logic signed [ZW-1:0] HALF_PI = ZW'(scale_q30(64'd1686629713));

  typedef enum logic [1:0] {IDLE, ROT, GAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic signed [XW-1:0]  x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]  z_q, z_d;
  logic [4:0]            i_q, i_d;
  logic                  zero_q, zero_d;
  logic signed [XW-1:0]  x_ext, y_ext, x_sh, y_sh;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = XW + FRAC_BITS + 1;
  localparam logic [FRAC_BITS:0] INV_K = (FRAC_BITS + 1)'(scale_q30(64'd652032874));
  logic signed [PW-1:0] prod, prod_rnd;
  assign prod     = x_q * $signed(INV_K);
  assign prod_rnd = prod + (PW'(1) <<< (FRAC_BITS - 1));
`endif

  assign x_ext = {{2{x_in[IW-1]}}, x_in};
  assign y_ext = {{2{y_in[IW-1]}}, y_in};
  assign x_sh  = x_q >>> i_q;
  assign y_sh  = y_q >>> i_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Fold the left half-plane onto the right so the iterations only need +-pi/2 of reach.
          if (!x_in[IW-1]) begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end else if (!y_in[IW-1]) begin
            x_d = y_ext;
            y_d = -x_ext;
            z_d = HALF_PI;
          end else begin
            x_d = -y_ext;
            y_d = x_ext;
            z_d = -HALF_PI;
          end
          zero_d  = (x_in == '0) && (y_in == '0);
          i_d     = '0;
          state_d = ROT;
        end
      end
      ROT: begin
        if (!y_q[XW-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_lut(i_q);
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_lut(i_q);
        end
        if (i_q == LAST_IDX) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = GAIN;
`else
          state_d = DONE;
`endif
        end else begin
          i_d = i_q + 5'd1;
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      GAIN: begin
        x_d     = prod_rnd[FRAC_BITS +: XW];
        state_d = DONE;
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign mag_out   = (out_valid && !zero_q) ? x_q : '0;
  assign angle_out = (out_valid && !zero_q) ? z_q : '0;

endmodule
